// File: rtl/nonce_collector.sv
// -----------------------------------------------------------------------------
// nonce_collector
//
// Downstream collector for a bank of parallel nonce search workers. A job is
// started with job_start, which enables every worker. Each worker raises its
// check flag (a level) when it finds a golden nonce. The collector detects the
// rising edge, marks the worker pending, and a round-robin arbiter moves at
// most one pending result per cycle into a small show-ahead FIFO. The FIFO
// drains over a valid/ready handshake. The job ends after MAX_RESULTS results
// or on job_abort. The workers are then disabled, and the collector returns
// to idle once everything already captured has been delivered.
//
// Optional feature macro: NONCE_COLLECTOR_HASH_EN
//   When defined, the per-worker 256-bit hash is captured alongside the nonce.
//   The ports worker_hash and out_hash exist only in that build.
//
// Parameters:
//   NUM_WORKERS  number of workers (>= 2)
//   FIFO_DEPTH   result FIFO entries (power of two, >= 2)
//   MAX_RESULTS  results per job before the search stops (1..255)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   job_start      pulse; starts a job when idle
//   job_abort      pulse; stops the search
//   worker_check   per-worker found flag (level)
//   worker_nonce   per-worker nonce, worker i at [32i+31:32i]
//   worker_hash    per-worker hash (hash build only)
//   worker_enable  enable to every worker
//   out_valid      FIFO head valid
//   out_ready      consumer accepts the head
//   out_nonce      head nonce
//   out_worker     head worker index
//   out_hash       head hash (hash build only)
//   busy           collector not idle
//   overflow       sticky: a hit was lost; cleared on job_start
// -----------------------------------------------------------------------------
module nonce_collector #(
    parameter int NUM_WORKERS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_RESULTS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           job_start,
    input  logic                           job_abort,
    input  logic [NUM_WORKERS-1:0]         worker_check,
    input  logic [32*NUM_WORKERS-1:0]      worker_nonce,
`ifdef NONCE_COLLECTOR_HASH_EN
    input  logic [256*NUM_WORKERS-1:0]     worker_hash,
`endif
    output logic                           worker_enable,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_nonce,
    output logic [$clog2(NUM_WORKERS)-1:0] out_worker,
`ifdef NONCE_COLLECTOR_HASH_EN
    output logic [255:0]                   out_hash,
`endif
    output logic                           busy,
    output logic                           overflow
);

    localparam int IDX_W = $clog2(NUM_WORKERS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                 state;
    logic [NUM_WORKERS-1:0] prev_check;
    logic [NUM_WORKERS-1:0] pending;
    logic [NUM_WORKERS-1:0] edges;
    logic [NUM_WORKERS-1:0] captured;
    logic [NUM_WORKERS-1:0] grant_mask;
    logic [CNT_W-1:0]       result_cnt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       cand;
    logic                   grant_valid;
    logic                   push;
    logic                   pop;
    logic                   last_result;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [31:0]            grant_nonce;

    logic [31:0]            mem_nonce  [FIFO_DEPTH];
    logic [IDX_W-1:0]       mem_worker [FIFO_DEPTH];

`ifdef NONCE_COLLECTOR_HASH_EN
    logic [255:0]           grant_hash;
    logic [255:0]           mem_hash   [FIFO_DEPTH];
`endif

    // (base + off) mod NUM_WORKERS; both operands are below NUM_WORKERS, so
    // one conditional subtraction is enough.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W+1)'(off);
        if (sum >= (IDX_W+1)'(NUM_WORKERS))
            sum = sum - (IDX_W+1)'(NUM_WORKERS);
        return sum[IDX_W-1:0];
    endfunction

    // Result counter increment, saturating at MAX_RESULTS.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(MAX_RESULTS))
            return v;
        return v + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Edge detection and round-robin arbitration
    // -------------------------------------------------------------------------
    assign edges    = worker_check & ~prev_check;
    assign captured = (state == SEARCH) ? edges : '0;

    // Walk from the highest offset down so the candidate closest to rr_ptr
    // is the one left in grant_idx.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
            cand = wrap_add(rr_ptr, k);
            if (pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_nonce = '0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            if (grant_idx == IDX_W'(k))
                grant_nonce = worker_nonce[32*k +: 32];
        end
    end

`ifdef NONCE_COLLECTOR_HASH_EN
    always_comb begin
        grant_hash = '0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            if (grant_idx == IDX_W'(k))
                grant_hash = worker_hash[256*k +: 256];
        end
    end
`endif

    // -------------------------------------------------------------------------
    // FIFO status and push/pop decisions
    // -------------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    // Once the counter has reached MAX_RESULTS nothing further is pushed.
    assign push = grant_valid && (state != IDLE) &&
                  (result_cnt != CNT_W'(MAX_RESULTS)) &&
                  (!fifo_full || pop);

    assign last_result = push && (sat_inc(result_cnt) == CNT_W'(MAX_RESULTS));
    assign grant_mask  = push ? (NUM_WORKERS'(1) << grant_idx) : '0;

    // -------------------------------------------------------------------------
    // Control state: FSM, pending bits, pointers, counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            worker_enable <= 1'b0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            pending       <= '0;
            prev_check    <= '0;
            rr_ptr        <= '0;
            result_cnt    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            prev_check <= worker_check;

            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                rr_ptr     <= wrap_add(grant_idx, 1);
                result_cnt <= sat_inc(result_cnt);
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            // A new edge on a worker whose previous hit is still waiting
            // would overwrite it; that hit is lost. If the old hit leaves
            // this very cycle, the new one simply becomes pending.
            if (|(captured & pending & ~grant_mask))
                overflow <= 1'b1;

            // Reaching MAX_RESULTS discards every hit still waiting.
            if (last_result)
                pending <= '0;
            else
                pending <= (pending & ~grant_mask) | captured;

            case (state)
                IDLE: begin
                    if (job_start) begin
                        state         <= SEARCH;
                        worker_enable <= 1'b1;
                        busy          <= 1'b1;
                        result_cnt    <= '0;
                        pending       <= '0;
                        prev_check    <= '0;
                        overflow      <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (last_result || job_abort) begin
                        state         <= DRAIN;
                        worker_enable <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && (pending == '0)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    worker_enable <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (data only, no reset; outputs are gated by out_valid)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_nonce[wr_ptr[AW-1:0]]  <= grant_nonce;
            mem_worker[wr_ptr[AW-1:0]] <= grant_idx;
`ifdef NONCE_COLLECTOR_HASH_EN
            mem_hash[wr_ptr[AW-1:0]]   <= grant_hash;
`endif
        end
    end

    // Show-ahead head; forced to zero while empty so reset and idle values
    // are well defined without resetting the storage.
    assign out_nonce  = out_valid ? mem_nonce[rd_ptr[AW-1:0]]  : '0;
    assign out_worker = out_valid ? mem_worker[rd_ptr[AW-1:0]] : '0;
`ifdef NONCE_COLLECTOR_HASH_EN
    assign out_hash   = out_valid ? mem_hash[rd_ptr[AW-1:0]]   : '0;
`endif

endmodule

// File: tb/tb_nonce_collector.sv
// -----------------------------------------------------------------------------
// tb_nonce_collector
//
// Two collectors share all inputs: u_single (MAX_RESULTS=1) and u_multi
// (MAX_RESULTS=8), both with 4 workers and a 4-entry FIFO. `sel` chooses
// which one the scoreboard monitor follows. Expected results are queued when
// a hit is driven and compared when the selected DUT hands them out.
// -----------------------------------------------------------------------------
module tb_nonce_collector;

    typedef struct packed {
        logic [1:0]  w;
        logic [31:0] n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_start;
    logic         job_abort;
    logic         out_ready;
    logic [3:0]   worker_check;
    logic [127:0] worker_nonce;
`ifdef NONCE_COLLECTOR_HASH_EN
    logic [1023:0] worker_hash;
    logic [255:0]  hash0, hash1;
`endif

    logic        en0, valid0, busy0, ovf0;
    logic [31:0] nonce0;
    logic [1:0]  worker0;
    logic        en1, valid1, busy1, ovf1;
    logic [31:0] nonce1;
    logic [1:0]  worker1;

    bit   sel;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    nonce_collector #(.NUM_WORKERS(4), .FIFO_DEPTH(4), .MAX_RESULTS(1)) u_single (
        .clk(clk), .rst(rst), .job_start(job_start), .job_abort(job_abort),
        .worker_check(worker_check), .worker_nonce(worker_nonce),
`ifdef NONCE_COLLECTOR_HASH_EN
        .worker_hash(worker_hash), .out_hash(hash0),
`endif
        .worker_enable(en0), .out_valid(valid0), .out_ready(out_ready),
        .out_nonce(nonce0), .out_worker(worker0), .busy(busy0), .overflow(ovf0)
    );

    nonce_collector #(.NUM_WORKERS(4), .FIFO_DEPTH(4), .MAX_RESULTS(8)) u_multi (
        .clk(clk), .rst(rst), .job_start(job_start), .job_abort(job_abort),
        .worker_check(worker_check), .worker_nonce(worker_nonce),
`ifdef NONCE_COLLECTOR_HASH_EN
        .worker_hash(worker_hash), .out_hash(hash1),
`endif
        .worker_enable(en1), .out_valid(valid1), .out_ready(out_ready),
        .out_nonce(nonce1), .out_worker(worker1), .busy(busy1), .overflow(ovf1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    wire        m_valid  = sel ? valid1  : valid0;
    wire [31:0] m_nonce  = sel ? nonce1  : nonce0;
    wire [1:0]  m_worker = sel ? worker1 : worker0;

    // Scoreboard: every accepted head is compared against the oldest
    // expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && m_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got worker %0d nonce %h, required no output",
                         m_worker, m_nonce);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_worker !== e.w || m_nonce !== e.n) begin
                    errors++;
                    $display("FAIL sb_result: got worker %0d nonce %h, required worker %0d nonce %h",
                             m_worker, m_nonce, e.w, e.n);
                end
            end
        end
    end

    function automatic logic cur_busy();
        return sel ? busy1 : busy0;
    endfunction

    task automatic set_nonce(input int i, input logic [31:0] v);
        worker_nonce[32*i +: 32] = v;
    endtask

    task automatic expect_result(input logic [1:0] w, input logic [31:0] n);
        exp_t e;
        e.w = w;
        e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        job_start    = 1'b0;
        job_abort    = 1'b0;
        out_ready    = 1'b0;
        worker_check = '0;
        worker_nonce = '0;
`ifdef NONCE_COLLECTOR_HASH_EN
        worker_hash  = '0;
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic start_job();
        @(posedge clk);
        #1 job_start = 1'b1;
        @(posedge clk);
        #1 job_start = 1'b0;
    endtask

    task automatic abort_job();
        @(posedge clk);
        #1 job_abort = 1'b1;
        @(posedge clk);
        #1 job_abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (cur_busy() !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cur_busy() !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, cur_busy(), n);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results never output, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b0;
        job_start = 1'b0; job_abort = 1'b0; out_ready = 1'b0;
        worker_check = '0; worker_nonce = '0;
`ifdef NONCE_COLLECTOR_HASH_EN
        worker_hash = '0;
`endif
        #3;
        checks++;
        if ({en0, valid0, busy0, ovf0} !== 4'b0000 || nonce0 !== 32'h0 || worker0 !== 2'd0) begin
            errors++;
            $display("FAIL reset_single: en/valid/busy/ovf=%b nonce=%h worker=%0d, required 0000/0/0",
                     {en0, valid0, busy0, ovf0}, nonce0, worker0);
        end
        checks++;
        if ({en1, valid1, busy1, ovf1} !== 4'b0000 || nonce1 !== 32'h0 || worker1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_multi: en/valid/busy/ovf=%b nonce=%h worker=%0d, required 0000/0/0",
                     {en1, valid1, busy1, ovf1}, nonce1, worker1);
        end
        do_reset();
    endtask

    task automatic test_single_hit();
        sel = 1'b0;
        do_reset();
        out_ready = 1'b1;
        start_job();
        @(negedge clk);
        checks++;
        if (en0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL sh_start: enable=%b busy=%b, required 1 1", en0, busy0);
        end
        @(posedge clk);
        #1;
        set_nonce(2, 32'h0000_1234);
        worker_check[2] = 1'b1;
        expect_result(2'd2, 32'h0000_1234);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL sh_latency_early: out_valid=%b one cycle after the rise, required 0", valid0);
        end
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b1 || nonce0 !== 32'h1234 || worker0 !== 2'd2) begin
            errors++;
            $display("FAIL sh_output: valid=%b nonce=%h worker=%0d, required 1 00001234 2",
                     valid0, nonce0, worker0);
        end
        checks++;
        if (en0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL sh_drain: enable=%b busy=%b, required 0 1", en0, busy0);
        end
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL sh_one_cycle: out_valid=%b after the pop, required 0", valid0);
        end
        wait_idle("sh_busy_fall");
        worker_check = '0;
        check_queue_empty("sh_queue");
    endtask

    task automatic test_simultaneous();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b1;
        start_job();
        @(posedge clk);
        #1;
        set_nonce(1, 32'h1111_0001);
        set_nonce(3, 32'h3333_0003);
        worker_check = 4'b1010;
        expect_result(2'd1, 32'h1111_0001);
        expect_result(2'd3, 32'h3333_0003);
        repeat (3) @(negedge clk);
        checks++;
        if (valid1 !== 1'b1 || worker1 !== 2'd1) begin
            errors++;
            $display("FAIL sim_first: valid=%b worker=%0d, required 1 1", valid1, worker1);
        end
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b1 || worker1 !== 2'd3) begin
            errors++;
            $display("FAIL sim_second: valid=%b worker=%0d, required 1 3", valid1, worker1);
        end
        @(posedge clk);
        #1 worker_check = '0;
        @(posedge clk);
        #1;
        set_nonce(0, 32'h0A0A_0A0A);
        set_nonce(3, 32'h3B3B_3B3B);
        worker_check = 4'b1001;
        expect_result(2'd0, 32'h0A0A_0A0A);
        expect_result(2'd3, 32'h3B3B_3B3B);
        repeat (3) @(negedge clk);
        checks++;
        if (valid1 !== 1'b1 || worker1 !== 2'd0) begin
            errors++;
            $display("FAIL sim_rr_first: valid=%b worker=%0d, required 1 0", valid1, worker1);
        end
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b1 || worker1 !== 2'd3) begin
            errors++;
            $display("FAIL sim_rr_second: valid=%b worker=%0d, required 1 3", valid1, worker1);
        end
        @(posedge clk);
        #1 worker_check = '0;
        abort_job();
        wait_idle("sim_idle");
        check_queue_empty("sim_queue");
    endtask

    task automatic test_back_pressure();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b0;
        start_job();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            set_nonce(i, 32'hB000_0000 + i);
            expect_result(2'(i), 32'hB000_0000 + i);
        end
        worker_check = 4'b1111;
        repeat (6) @(posedge clk);
        #1 worker_check[0] = 1'b0;
        @(posedge clk);
        #1;
        set_nonce(0, 32'hB000_0005);
        worker_check[0] = 1'b1;
        expect_result(2'd0, 32'hB000_0005);
        repeat (3) @(negedge clk);
        checks++;
        if (valid1 !== 1'b1 || worker1 !== 2'd0 || nonce1 !== 32'hB000_0000) begin
            errors++;
            $display("FAIL bp_head_hold: valid=%b worker=%0d nonce=%h, required 1 0 b0000000",
                     valid1, worker1, nonce1);
        end
        checks++;
        if (ovf1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_overflow: overflow=%b busy=%b, required 0 1", ovf1, busy1);
        end
    endtask

    // Continues from the full FIFO left by test_back_pressure.
    task automatic test_overflow();
        int n = 0;
        @(posedge clk);
        #1 worker_check[0] = 1'b0;
        @(posedge clk);
        #1 worker_check[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: overflow=%b, required 1", ovf1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_queue_empty("bp_drain_all");
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b0 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_drain: valid=%b overflow=%b, required 0 1", valid1, ovf1);
        end
        worker_check = '0;
        abort_job();
        wait_idle("ovf_idle");
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_idle: overflow=%b, required 1", ovf1);
        end
        start_job();
        @(negedge clk);
        checks++;
        if (ovf1 !== 1'b0 || en1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b enable=%b, required 0 1", ovf1, en1);
        end
        abort_job();
        wait_idle("ovf_idle2");
    endtask

    task automatic test_abort();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b1;
        start_job();
        @(posedge clk);
        #1;
        set_nonce(1, 32'hAB00_0001);
        set_nonce(2, 32'hAB00_0002);
        worker_check = 4'b0110;
        job_abort = 1'b1;
        expect_result(2'd1, 32'hAB00_0001);
        expect_result(2'd2, 32'hAB00_0002);
        @(posedge clk);
        #1 job_abort = 1'b0;
        @(negedge clk);
        checks++;
        if (en1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_drain: enable=%b busy=%b, required 0 1", en1, busy1);
        end
        wait_idle("abort_idle");
        check_queue_empty("abort_queue");
        worker_check = '0;
    endtask

    task automatic test_reset_mid_drain();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b0;
        start_job();
        @(posedge clk);
        #1;
        set_nonce(3, 32'hDEAD_BEEF);
        worker_check[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1 job_abort = 1'b1;
        @(posedge clk);
        #1 job_abort = 1'b0;
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b1 || busy1 !== 1'b1 || en1 !== 1'b0 || nonce1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rst_pre: valid=%b busy=%b enable=%b nonce=%h, required 1 1 0 deadbeef",
                     valid1, busy1, en1, nonce1);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0 || en1 !== 1'b0 || nonce1 !== 32'h0 || worker1 !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_drain: valid=%b busy=%b enable=%b nonce=%h worker=%0d, required 0 0 0 0 0",
                     valid1, busy1, en1, nonce1, worker1);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_back_pressure();
        test_overflow();
        test_abort();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
